// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage with register file, load-use interlock and one output register
//
// Ports:
//   clock, reset_n           single clock, asynchronous active-low reset
//   IF_ID, in_valid/in_ready {pc, instr} input handshake
//   ID_EX, out_valid/out_ready
//                            {pc, rs_val, rt_val, imm_ext, dest, illegal, ctrl} output handshake
//   flush                    drops the held output and blocks acceptance this cycle
//   wb_en, wb_addr, wb_data  register-file write port (writeback)

module decode_stage #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int BYPASS = 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [PC_W+31:0]           IF_ID,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PC_W+3*DATA_W+13:0]  ID_EX,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       flush,
    input  logic                       wb_en,
    input  logic [4:0]                 wb_addr,
    input  logic [DATA_W-1:0]          wb_data
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // ctrl = {reg_write, mem_read, mem_write, alu_src_imm, branch, alu_op[2:0]}
    localparam logic [7:0] CTRL_RTYPE = 8'h80;
    localparam logic [7:0] CTRL_ADDI  = 8'h91;
    localparam logic [7:0] CTRL_LW    = 8'hD1;
    localparam logic [7:0] CTRL_SW    = 8'h31;
    localparam logic [7:0] CTRL_BEQ   = 8'h0A;

    logic [PC_W-1:0]   pc;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;

    assign pc     = IF_ID[PC_W+31:32];
    assign opcode = IF_ID[31:26];
    assign rs     = IF_ID[25:21];
    assign rt     = IF_ID[20:16];
    assign rd     = IF_ID[15:11];
    assign imm    = IF_ID[15:0];

    logic [DATA_W-1:0] rf [32];
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;
    logic [7:0]        ctrl;
    logic [4:0]        dest;
    logic              illegal;
    logic              hazard;
    logic              accept;
    logic              rt_is_src;
    logic [4:0]        held_dest;
    logic              held_mem_read;

    // Register 0 is never written, and reads of it are forced to zero here.
    always_comb begin
        rs_val = '0;
        if (rs != 5'd0) begin
            if ((BYPASS != 0) && wb_en && (wb_addr == rs))
                rs_val = wb_data;
            else
                rs_val = rf[rs];
        end
    end

    always_comb begin
        rt_val = '0;
        if (rt != 5'd0) begin
            if ((BYPASS != 0) && wb_en && (wb_addr == rt))
                rt_val = wb_data;
            else
                rt_val = rf[rt];
        end
    end

    assign imm_ext = DATA_W'($signed(imm));

    always_comb begin
        ctrl    = '0;
        dest    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin ctrl = CTRL_RTYPE; dest = rd; end
            OP_ADDI:  begin ctrl = CTRL_ADDI;  dest = rt; end
            OP_LW:    begin ctrl = CTRL_LW;    dest = rt; end
            OP_SW:    ctrl = CTRL_SW;
            OP_BEQ:   ctrl = CTRL_BEQ;
            default:  illegal = 1'b1;
        endcase
    end

    // Load-use interlock: the held LW's result is not available yet, so an
    // instruction that sources its destination must wait one bubble. rt is
    // only a source for R-type, SW and BEQ; for ADDI/LW it is the destination.
    assign held_dest     = ID_EX[13:9];
    assign held_mem_read = ID_EX[6];
    assign rt_is_src     = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    assign hazard        = out_valid && held_mem_read && (held_dest != 5'd0) &&
                           ((held_dest == rs) || (rt_is_src && (held_dest == rt)));

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= '0;
        end else if (wb_en && (wb_addr != 5'd0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            ID_EX     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            ID_EX     <= {pc, rs_val, rt_val, imm_ext, dest, illegal, ctrl};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
